// File: rtl/simple_bus_slave_mem.sv
// simple_bus responder: req/gnt ownership, start-qualified read/write/read-clear
// commands against a small word store, programmable wait states, one-cycle rdy.
module simple_bus_slave_mem #(
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req,
  output logic       gnt,
  input  logic       start,
  input  logic [7:0] addr,
  input  logic [1:0] mode,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       data_oe,
  output logic       rdy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] MODE_READ  = 2'b00;
  localparam logic [1:0] MODE_WRITE = 2'b01;
  localparam logic [1:0] MODE_RCLR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         mode_q, mode_d;
  logic [7:0]         wdata_q, wdata_d;
  logic               gnt_q, gnt_d;
  logic               rdy_q, rdy_d;
  logic               data_oe_q, data_oe_d;
  logic [7:0]         data_o_q, data_o_d;

  logic               mem_we;
  logic [7:0]         mem_wdata;
  logic [7:0]         mem_rd [DEPTH];

  logic               enter_done;
  logic [IDX_W-1:0]   done_idx;
  logic [1:0]         done_mode;

  // Only the low index bits select a word; higher address bits alias.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    mode_d     = mode_q;
    wdata_d    = wdata_q;
    gnt_d      = gnt_q;
    rdy_d      = 1'b0;
    data_oe_d  = 1'b0;
    data_o_d   = 8'h00;
    mem_we     = 1'b0;
    mem_wdata  = wdata_q;
    enter_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        gnt_d = 1'b0;
        if (req) begin
          state_d = S_GRANT;
          gnt_d   = 1'b1;
        end
      end
      S_GRANT: begin
        gnt_d = 1'b1;
        // A start wins over a simultaneous req drop; release waits for DONE.
        if (start) begin
          idx_d   = addr[IDX_W-1:0];
          mode_d  = mode;
          wdata_d = data_i;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end else begin
            state_d    = S_DONE;
            enter_done = 1'b1;
          end
        end else if (!req) begin
          state_d = S_IDLE;
          gnt_d   = 1'b0;
        end
      end
      S_WAIT: begin
        gnt_d = 1'b1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = S_DONE;
          enter_done = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (mode_q == MODE_WRITE) begin
          mem_we    = 1'b1;
          mem_wdata = wdata_q;
        end else if (mode_q == MODE_RCLR) begin
          mem_we    = 1'b1;
          mem_wdata = 8'h00;
        end
        state_d = req ? S_GRANT : S_IDLE;
        gnt_d   = req;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = 1'b0;
      end
    endcase

    // With zero wait states the command is still on the bus, not yet latched.
    done_idx  = (state_q == S_GRANT) ? addr[IDX_W-1:0] : idx_q;
    done_mode = (state_q == S_GRANT) ? mode : mode_q;
    if (enter_done) begin
      rdy_d = 1'b1;
      if (done_mode == MODE_READ || done_mode == MODE_RCLR) begin
        data_oe_d = 1'b1;
        data_o_d  = mem_rd[done_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      mode_q    <= 2'b00;
      wdata_q   <= 8'h00;
      gnt_q     <= 1'b0;
      rdy_q     <= 1'b0;
      data_oe_q <= 1'b0;
      data_o_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      wdata_q   <= wdata_d;
      gnt_q     <= gnt_d;
      rdy_q     <= rdy_d;
      data_oe_q <= data_oe_d;
      data_o_q  <= data_o_d;
    end
  end

  // Word store: every word clears on reset, so each is an individual register.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
    logic [7:0] word_q, word_d;

    always_comb begin
      word_d = word_q;
      if (mem_we && (idx_q == IDX_W'(gi))) begin
        word_d = mem_wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        word_q <= 8'h00;
      end else begin
        word_q <= word_d;
      end
    end

    assign mem_rd[gi] = word_q;
  end

  assign gnt     = gnt_q;
  assign rdy     = rdy_q;
  assign data_oe = data_oe_q;
  assign data_o  = data_o_q;

endmodule

// File: tb/tb_simple_bus_slave_mem.sv
// Scoreboard bench for simple_bus_slave_mem: three instances with different
// DEPTH/WAIT_STATES, expected completions queued at start and checked on rdy.
`timescale 1ns/1ps
module tb_simple_bus_slave_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n   [3];
  logic       req     [3];
  logic       start   [3];
  logic [7:0] addr    [3];
  logic [1:0] mode    [3];
  logic [7:0] data_i  [3];
  logic       gnt     [3];
  logic [7:0] data_o  [3];
  logic       data_oe [3];
  logic       rdy     [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    simple_bus_slave_mem #(
      .DEPTH      ((gi == 1) ? 16 : 256),
      .WAIT_STATES((gi == 0) ? 0 : ((gi == 1) ? 3 : 2))
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n[gi]),
      .req    (req[gi]),
      .gnt    (gnt[gi]),
      .start  (start[gi]),
      .addr   (addr[gi]),
      .mode   (mode[gi]),
      .data_i (data_i[gi]),
      .data_o (data_o[gi]),
      .data_oe(data_oe[gi]),
      .rdy    (rdy[gi])
    );
  end

  function automatic int dp_of(int d);
    return (d == 1) ? 16 : 256;
  endfunction

  function automatic int ws_of(int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 2);
  endfunction

  typedef struct {
    int         dut;
    int         due;
    logic [7:0] data;
    logic       oe;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model_mem [3][256];
  int         checks   = 0;
  int         failures = 0;
  int         cyc      = 0;
  bit         mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard on every rdy and polices idle outputs.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 3; d++) begin
        chk_val($sformatf("oe_without_rdy_d%0d", d), 32'(data_oe[d] & ~rdy[d]), 0);
        if (!data_oe[d]) chk_val($sformatf("data_o_idle_d%0d", d), 32'(data_o[d]), 0);
        if (rdy[d]) begin
          if (sb.size() == 0 || sb[0].dut != d) begin
            chk_val($sformatf("spurious_rdy_d%0d", d), 32'(rdy[d]), 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            $display("txn d%0d cycle=%0d data_o=0x%02h data_oe=%0b", d, cyc, data_o[d], data_oe[d]);
            chk_val($sformatf("rdy_cycle_d%0d", d), 32'(cyc), 32'(e.due));
            chk_val($sformatf("data_o_d%0d", d), 32'(data_o[d]), 32'(e.data));
            chk_val($sformatf("data_oe_d%0d", d), 32'(data_oe[d]), 32'(e.oe));
            chk_val($sformatf("gnt_at_rdy_d%0d", d), 32'(gnt[d]), 1);
          end
        end
      end
      if (sb.size() != 0 && cyc > sb[0].due) begin
        chk_val($sformatf("rdy_missing_d%0d", sb[0].dut), 32'(cyc), 32'(sb[0].due));
        void'(sb.pop_front());
      end
    end
  end

  task automatic request(input int d);
    @(negedge clk);
    req[d] = 1'b1;
    chk_val($sformatf("gnt_before_edge_d%0d", d), 32'(gnt[d]), 0);
    @(negedge clk);
    chk_val($sformatf("gnt_after_req_d%0d", d), 32'(gnt[d]), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
  endtask

  // Issue one command from GRANT; optionally poke a second start during WAIT.
  task automatic xact(input int d, input logic [1:0] m, input logic [7:0] a,
                      input logic [7:0] wd, input bit poke, input bit drop_req);
    exp_t e;
    int   idx;
    idx   = int'(a) % dp_of(d);
    e.dut = d;
    e.data = 8'h00;
    e.oe   = 1'b0;
    case (m)
      2'b00: begin e.data = model_mem[d][idx]; e.oe = 1'b1; end
      2'b10: begin e.data = model_mem[d][idx]; e.oe = 1'b1; model_mem[d][idx] = 8'h00; end
      2'b01: model_mem[d][idx] = wd;
      default: ;
    endcase
    @(negedge clk);
    start[d]  = 1'b1;
    mode[d]   = m;
    addr[d]   = a;
    data_i[d] = wd;
    e.due = cyc + 1 + ws_of(d);
    sb.push_back(e);
    @(negedge clk);
    start[d]  = 1'b0;
    addr[d]   = ~a;
    data_i[d] = ~wd;
    if (drop_req) req[d] = 1'b0;
    if (poke) begin
      @(negedge clk);
      start[d]  = 1'b1;
      mode[d]   = 2'b01;
      addr[d]   = a + 8'd1;
      data_i[d] = 8'hEE;
      @(negedge clk);
      start[d]  = 1'b0;
    end
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rd;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; start[d] = 1'b0;
      addr[d] = 8'h00; mode[d] = 2'b00; data_i[d] = 8'h00;
      for (int i = 0; i < 256; i++) model_mem[d][i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk_val($sformatf("reset_gnt_d%0d", d), 32'(gnt[d]), 0);
      chk_val($sformatf("reset_rdy_d%0d", d), 32'(rdy[d]), 0);
      chk_val($sformatf("reset_oe_d%0d", d), 32'(data_oe[d]), 0);
      chk_val($sformatf("reset_data_o_d%0d", d), 32'(data_o[d]), 0);
      rst_n[d] = 1'b1;
    end
    mon_en = 1'b1;

    // Instance 0: DEPTH 256, no wait states
    request(0);
    xact(0, 2'b01, 8'h12, 8'hA5, 0, 0);
    xact(0, 2'b00, 8'h12, 8'h00, 0, 0);
    xact(0, 2'b01, 8'h40, 8'h3C, 0, 0);
    xact(0, 2'b10, 8'h40, 8'h00, 0, 0);
    xact(0, 2'b00, 8'h40, 8'h00, 0, 0);
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom_range(0, 255));
      rd = 8'($urandom_range(0, 255));
      xact(0, 2'b01, ra, rd, 0, 0);
      xact(0, 2'b00, ra, 8'h00, 0, 0);
    end
    @(negedge clk);
    req[0] = 1'b0;
    @(negedge clk);
    chk_val("gnt_released_d0", 32'(gnt[0]), 0);
    start[0] = 1'b1; mode[0] = 2'b01; addr[0] = 8'h12; data_i[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk_val("gnt_no_owner_d0", 32'(gnt[0]), 0);
    request(0);
    xact(0, 2'b00, 8'h12, 8'h00, 0, 0);

    // Instance 1: DEPTH 16, three wait states
    request(1);
    xact(1, 2'b00, 8'h00, 8'h00, 1, 0);
    xact(1, 2'b01, 8'h25, 8'h77, 0, 0);
    xact(1, 2'b00, 8'h05, 8'h00, 0, 0);
    xact(1, 2'b11, 8'h05, 8'h11, 0, 0);
    xact(1, 2'b00, 8'h05, 8'h00, 0, 0);
    xact(1, 2'b10, 8'hF5, 8'h00, 0, 0);
    xact(1, 2'b00, 8'h25, 8'h00, 0, 0);

    // Instance 2: DEPTH 256, two wait states; req dropped mid-transaction
    request(2);
    xact(2, 2'b01, 8'h33, 8'h5A, 0, 1);
    chk_val("gnt_after_drop_d2", 32'(gnt[2]), 0);
    request(2);
    xact(2, 2'b00, 8'h33, 8'h00, 0, 0);

    // Reset during WAIT of a write: command dropped, store cleared
    @(negedge clk);
    start[2] = 1'b1; mode[2] = 2'b01; addr[2] = 8'h10; data_i[2] = 8'hFF;
    @(negedge clk);
    start[2] = 1'b0;
    rst_n[2] = 1'b0;
    @(negedge clk);
    chk_val("gnt_in_reset_d2", 32'(gnt[2]), 0);
    chk_val("rdy_in_reset_d2", 32'(rdy[2]), 0);
    rst_n[2] = 1'b1;
    for (int i = 0; i < 256; i++) model_mem[2][i] = 8'h00;
    @(negedge clk);
    chk_val("gnt_after_reset_d2", 32'(gnt[2]), 1);
    xact(2, 2'b00, 8'h10, 8'h00, 0, 0);
    xact(2, 2'b00, 8'h33, 8'h00, 0, 0);

    repeat (4) @(negedge clk);
    chk_val("scoreboard_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
